// File: rtl/add_seq.sv
// Multi-cycle add/sub: a +/- b over WIDTH bits, CHUNK bits per clock, with valid/ready handshakes.
// Optional ovf/zero result flags when ADD_SEQ_FLAGS_EN is defined.
module add_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADD_SEQ_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              c_r;
    logic [IDXW-1:0]   idx_r;
    logic [CHUNK:0]    sum_s;
    logic [WIDTH-1:0]  s_next_s;
    logic              last_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
    end

    // One chunk of the carry chain, and s with that chunk merged in
    always_comb begin
        last_s   = (idx_r == LAST_IDX);
        sum_s    = {1'b0, a_r[idx_r*CHUNK +: CHUNK]} + {1'b0, b_r[idx_r*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_r};
        s_next_s = s;
        s_next_s[idx_r*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
    end

    // Operand capture and chunk-by-chunk result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            idx_r <= {IDXW{1'b0}};
            s     <= {WIDTH{1'b0}};
            cout  <= 1'b0;
`ifdef ADD_SEQ_FLAGS_EN
            ovf   <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        c_r   <= cin | sub;
                        idx_r <= {IDXW{1'b0}};
                    end
                end
                RUN: begin
                    s   <= s_next_s;
                    c_r <= sum_s[CHUNK];
                    if (last_s) begin
                        cout <= sum_s[CHUNK];
`ifdef ADD_SEQ_FLAGS_EN
                        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s_next_s[WIDTH-1] != a_r[WIDTH-1]);
                        zero <= (s_next_s == {WIDTH{1'b0}});
`endif
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq: three instances (CHUNK 4, 16, 1) at WIDTH 16.
// Checks flags as well when ADD_SEQ_FLAGS_EN is defined.
module tb_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  iv  = 3'b000;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  co;
    logic [2:0]  fo;
    logic [2:0]  fz;
    logic [15:0] sv [3];
    logic [15:0] a   = 16'h0000;
    logic [15:0] b   = 16'h0000;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    add_seq #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .s(sv[0]), .cout(co[0])
`ifdef ADD_SEQ_FLAGS_EN
        , .ovf(fo[0]), .zero(fz[0])
`endif
    );

    add_seq #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .s(sv[1]), .cout(co[1])
`ifdef ADD_SEQ_FLAGS_EN
        , .ovf(fo[1]), .zero(fz[1])
`endif
    );

    add_seq #(.WIDTH(16), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .s(sv[2]), .cout(co[2])
`ifdef ADD_SEQ_FLAGS_EN
        , .ovf(fo[2]), .zero(fz[2])
`endif
    );

`ifndef ADD_SEQ_FLAGS_EN
    assign fo = 3'b000;
    assign fz = 3'b000;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operation on instance sel, wait for the result, check it, then drain it.
    task automatic do_op(input int sel, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub, input logic [15:0] es,
                         input logic ec, input int elat, input logic eovf, input logic ezero);
        int lat;
        @(negedge clk);
        chk("in_ready_pre", {31'd0, ir[sel]}, 32'd1);
        a = ta; b = tb_v; cin = tcin; sub = tsub; iv[sel] = 1'b1;
        @(posedge clk);
        #1;
        iv[sel] = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("s", {16'd0, sv[sel]}, {16'd0, es});
        chk("cout", {31'd0, co[sel]}, {31'd0, ec});
`ifdef ADD_SEQ_FLAGS_EN
        if (sel == 0) begin
            chk("ovf", {31'd0, fo[0]}, {31'd0, eovf});
            chk("zero", {31'd0, fz[0]}, {31'd0, ezero});
        end
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_post", {31'd0, ir[sel]}, 32'd1);
        chk("out_valid_post", {31'd0, ov[sel]}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("rst_s", {16'd0, sv[0]}, 32'd0);
        chk("rst_cout", {31'd0, co[0]}, 32'd0);
        chk("rst_flags", {30'd0, fo[0], fz[0]}, 32'd0);

        do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 4, 1'b0, 1'b0);
        do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4, 1'b0, 1'b0);
        do_op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 4, 1'b0, 1'b0);
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4, 1'b0, 1'b1);
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 4, 1'b1, 1'b0);

        // Backpressure: result must hold while a competing request is ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid_rise", {31'd0, ov[0]}, 32'd1);
        a = 16'h0F0F; b = 16'h0F0F; iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_s", {16'd0, sv[0]}, 32'h3333);
            chk("bp_cout", {31'd0, co[0]}, 32'd0);
            chk("bp_valid", {31'd0, ov[0]}, 32'd1);
            chk("bp_in_ready", {31'd0, ir[0]}, 32'd0);
        end
        iv[0] = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_ready", {31'd0, ir[0]}, 32'd1);

        // Reset two cycles after acceptance discards the operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_s", {16'd0, sv[0]}, 32'd0);
        chk("mid_rst_cout", {31'd0, co[0]}, 32'd0);
        chk("mid_rst_valid", {31'd0, ov[0]}, 32'd0);
        chk("mid_rst_ready", {31'd0, ir[0]}, 32'd1);
        do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 4, 1'b0, 1'b0);

        // Degenerate chunk sizes
        do_op(1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 1'b1, 1'b1);
        do_op(2, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 16, 1'b1, 1'b1);
        do_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 16, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Parametrised, multi-cycle successor to the 8-bit ripple add/sub.
- Computes a ± b over WIDTH bits, CHUNK bits per clock, with one registered carry between chunks.
- Operand and result use a valid/ready handshake, so the ALU datapath can use wide operands without a WIDTH-deep combinational carry chain.
- Add/sub convention is unchanged: b is XORed with sub, and the effective carry-in is (cin | sub).

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle. 1 <= CHUNK <= WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  1 = subtract (a + ~b + 1).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB. For subtraction, 1 = no borrow.

Behaviour:
- Definitions: N = WIDTH/CHUNK. States are IDLE, RUN, DONE. Registers: a_r, b_r (b_r = b ^ {WIDTH{sub}}), c_r, idx (0..N-1), s.
- Reset (rst=1 at a clock edge):
  - state=IDLE, idx=0, s=0, cout=0, c_r=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides every other input.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from the state register; there is no combinational path from inputs to outputs.
- IDLE:
  - On in_valid & in_ready: latch a, b^sub, and c_r=(cin|sub). Set idx=0 and move to RUN.
  - in_valid while not IDLE is ignored. Operands are sampled only at acceptance and may change afterwards.
- RUN, each cycle:
  - {c, chunk} = a_r[idx*CHUNK +: CHUNK] + b_r[idx*CHUNK +: CHUNK] + c_r.
  - Write chunk to s[idx*CHUNK +: CHUNK] and set c_r=c.
  - If idx==N-1: cout=c, move to DONE. Otherwise idx=idx+1.
- Latency: out_valid rises exactly N cycles after the acceptance edge. With CHUNK==WIDTH, latency is 1.
- DONE:
  - s and cout hold stable while out_valid=1 and out_ready=0.
  - On out_ready=1: move to IDLE. in_ready=1 the next cycle.
  - No same-cycle accept. Back-to-back throughput is one operation per N+2 cycles.
- Wrap-around: arithmetic is modulo 2^WIDTH. Overflow past the MSB appears only on cout.
- s keeps its last value in IDLE and during RUN, updating chunk by chunk. s is only defined as the result while out_valid=1.
- Reset mid-RUN or mid-DONE discards the operation with no output. State is as for reset.

Optional Feature:
- Macro: ADD_SEQ_FLAGS_EN.
- When defined, adds two outputs, both valid with out_valid and held with s:
  - ovf  out  1  signed overflow = (a_r[MSB]==b_r[MSB]) & (s[MSB]!=a_r[MSB]).
  - zero  out  1  s==0, registered on the DONE transition.
  - Both reset to 0.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Add: a=0x00FF, b=0x0001, cin=0, sub=0, accepted at cycle t -> out_valid at t+4, s=0x0100, cout=0. With flags: ovf=0, zero=0.
- Sub with borrow: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1, cin=1 -> s=0x0002, cout=1 (cin|sub still adds only 1).
- Wrap and flags: a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, zero=1. Then a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> s, cout, out_valid stable; in_ready=0; a new in_valid is ignored. Raise out_ready -> in_ready=1 the next cycle.
- Reset mid-op: assert rst 2 cycles after acceptance -> next cycle s=0, cout=0, out_valid=0, in_ready=1. A following operation 0x1234+0x1111 gives 0x2345.
- Degenerate widths: CHUNK=16 -> 0x8000+0x8000 gives s=0x0000, cout=1, latency 1. CHUNK=1 -> latency 16, same result.
